microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Drives the microcode ROM address (opcode bank in [15:8], micro-step in [7:0]) and accepts the 32-bit control word it returns.
- Steps through the shared fetch/decode micro-steps and latches the opcode from the instruction register.
- Runs the opcode's execute micro-steps, then restarts fetch when the ROM returns an end marker.
- Sits between the instruction register/ROM and the datapath control lines. It is the only source of microcode addresses.

Parameters:
- FETCH_OPCODE, 8'h00, opcode bank used for the fetch/decode steps before an opcode is latched.
- OPCODE_LATCH_STEP, 8'd3, micro-step at whose end ir_opcode is captured.
- MAX_STEP, 8'd15, highest legal micro-step. Reaching it without an end marker is a fault.
- END_WORD, 32'h0000_0000, control-word value that marks end of instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run_en  in  1  level; 1 starts or continues execution from IDLE.
- halt_req  in  1  level; requests stop at the next instruction boundary.
- stall  in  1  freezes the step counter and suppresses the control word for this cycle.
- ir_opcode  in  8  opcode field from the instruction register.
- instr_mem_addr_out  out  16  {opcode_reg, step_reg} to the microcode ROM.
- instr_mem_data_in  in  32  control word from the ROM (combinational, same cycle).
- ctrl_word_out  out  32  gated control word to the datapath.
- step_out  out  8  current micro-step.
- instr_done  out  1  one-cycle pulse when an instruction completes.
- retired_count  out  16  number of completed instructions.
- halted  out  1  1 while in HALT.
- fault  out  1  sticky; set on a step overflow.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, opcode_reg=FETCH_OPCODE, step_reg=0, retired_count=0, fault=0.
  - All outputs 0, except instr_mem_addr_out = {FETCH_OPCODE, 8'h00}.
  - Reset asserted mid-instruction abandons it immediately; no instr_done is emitted.
- Address: instr_mem_addr_out = {opcode_reg, step_reg}, registered state only, no combinational path from inputs.
- ctrl_word_out:
  - Equals instr_mem_data_in when all of the following hold: state=RUN, stall=0, and data is not END_WORD.
  - Otherwise 32'h0.
  - Zero latency relative to the address; the ROM is combinational.
- States:
  - IDLE: outputs quiet. run_en=1 -> RUN at the next edge with step=0, opcode=FETCH_OPCODE.
  - RUN, stall=1: hold step_reg and opcode_reg; no other effect.
  - RUN, stall=0, data==END_WORD (end of instruction):
    - step_reg<=0, opcode_reg<=FETCH_OPCODE, instr_done pulses this cycle.
    - retired_count increments, wrapping 16'hFFFF -> 0.
    - If halt_req=1 -> HALT.
  - RUN, stall=0, step_reg==OPCODE_LATCH_STEP: opcode_reg<=ir_opcode, step_reg<=step_reg+1.
  - RUN, stall=0, step_reg==MAX_STEP and data!=END_WORD: fault<=1 -> HALT, step_reg<=0.
  - RUN, stall=0, otherwise: step_reg<=step_reg+1.
  - HALT: halted=1, ctrl_word_out=0, address held at {FETCH_OPCODE,0}.
    - Exit to RUN only when run_en=1 and halt_req=0.
    - fault is cleared only by rst.
- Boundary and simultaneous-event rules:
  - An end marker at step < OPCODE_LATCH_STEP is legal (fetch-only instruction); it completes normally.
  - stall and an end marker in the same cycle: stall wins; the end is processed on the first unstalled cycle.
  - halt_req is sampled only at an end marker; a mid-instruction halt_req never truncates the instruction.
  - run_en deassert while in RUN is ignored; only halt_req stops execution.

Test Plan:
- Bench ROM: opcode 0x00 steps 0..5 nonzero, step 6 = 0. Reset, run_en=1, ir_opcode=0x00 -> addresses 0x0000..0x0006 on consecutive cycles. instr_done pulses at address 0x0006, retired_count=1, next address 0x0000.
- Opcode 0x02 (ADD, steps 0..4, step 5 = 0) with ir_opcode=0x02 -> after step 3 the address is 0x0204. Done at 0x0205. Total 6 cycles per instruction, retired_count increments each time.
- Stall held 3 cycles at step 2 -> address frozen at {bank,0x02}, ctrl_word_out=0 for those cycles. Sequence resumes at step 3 with no step skipped.
- ROM returns nonzero through step 15 -> fault=1 and halted=1 at the next edge. ctrl_word_out=0 thereafter, until rst.
- halt_req=1 raised at step 1 -> instruction runs to its end marker, then halted=1. run_en=1 with halt_req=0 -> RUN again at address 0x0000.
- rst pulsed at step 4 -> immediately address=0x0000, ctrl_word_out=0, retired_count=0, no instr_done pulse.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - control, ROM and datapath signals of the microcode sequencer
interface microcode_sequencer_if;
   logic        run_en;
   logic        halt_req;
   logic        stall;
   logic [7:0]  ir_opcode;
   logic [15:0] instr_mem_addr_out;
   logic [31:0] instr_mem_data_in;
   logic [31:0] ctrl_word_out;
   logic [7:0]  step_out;
   logic        instr_done;
   logic [15:0] retired_count;
   logic        halted;
   logic        fault;

   modport master (
      input  run_en, halt_req, stall, ir_opcode, instr_mem_data_in,
      output instr_mem_addr_out, ctrl_word_out, step_out, instr_done,
             retired_count, halted, fault
   );

   modport slave (
      output run_en, halt_req, stall, ir_opcode, instr_mem_data_in,
      input  instr_mem_addr_out, ctrl_word_out, step_out, instr_done,
             retired_count, halted, fault
   );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode ROM sequencer: fetch/decode, opcode execute, end-marker restart
module microcode_sequencer #(
   parameter logic [7:0]  FETCH_OPCODE      = 8'h00,
   parameter logic [7:0]  OPCODE_LATCH_STEP = 8'd3,
   parameter logic [7:0]  MAX_STEP          = 8'd15,
   parameter logic [31:0] END_WORD          = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   microcode_sequencer_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  step_q, step_d;
   logic [15:0] retired_q, retired_d;
   logic        fault_q, fault_d;

   logic        is_end;

   assign is_end = (bus.instr_mem_data_in == END_WORD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         opcode_q  <= FETCH_OPCODE;
         step_q    <= 8'd0;
         retired_q <= 16'd0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         step_q    <= step_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      step_d    = step_q;
      retired_d = retired_q;
      fault_d   = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.run_en) begin
               state_d  = ST_RUN;
               step_d   = 8'd0;
               opcode_d = FETCH_OPCODE;
            end
         end
         ST_RUN: begin
            if (!bus.stall) begin
               if (is_end) begin
                  step_d    = 8'd0;
                  opcode_d  = FETCH_OPCODE;
                  retired_d = retired_q + 16'd1;
                  if (bus.halt_req) begin
                     state_d = ST_HALT;
                  end
               end else if (step_q == MAX_STEP) begin
                  fault_d  = 1'b1;
                  state_d  = ST_HALT;
                  step_d   = 8'd0;
                  opcode_d = FETCH_OPCODE;
               end else if (step_q == OPCODE_LATCH_STEP) begin
                  opcode_d = bus.ir_opcode;
                  step_d   = step_q + 8'd1;
               end else begin
                  step_d = step_q + 8'd1;
               end
            end
         end
         ST_HALT: begin
            step_d   = 8'd0;
            opcode_d = FETCH_OPCODE;
            // A step overflow pins the sequencer in HALT until reset.
            if (bus.run_en && !bus.halt_req && !fault_q) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            step_d   = 8'd0;
            opcode_d = FETCH_OPCODE;
         end
      endcase
   end

   always_comb begin
      bus.ctrl_word_out = 32'h0;
      bus.instr_done    = 1'b0;
      bus.halted        = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!bus.stall) begin
               if (is_end) begin
                  bus.instr_done = 1'b1;
               end else begin
                  bus.ctrl_word_out = bus.instr_mem_data_in;
               end
            end
         end
         ST_HALT: begin
            bus.halted = 1'b1;
         end
         default: begin
            bus.ctrl_word_out = 32'h0;
         end
      endcase
   end

   assign bus.instr_mem_addr_out = {opcode_q, step_q};
   assign bus.step_out           = step_q;
   assign bus.retired_count      = retired_q;
   assign bus.fault              = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - table-driven bench for microcode_sequencer with a behavioural ROM
module tb_microcode_sequencer;

   logic clk;
   logic rst;
   logic short_fetch;

   microcode_sequencer_if bus ();

   microcode_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank 00: fetch steps 0..5 live, end at 6 (or at 1 in short-fetch mode).
   // Bank 02: ADD, end at step 5. Bank 0F: never ends.
   function automatic logic [31:0] rom_data(input logic [15:0] addr, input logic sf);
      logic [7:0] bank;
      logic [7:0] st;
      bank = addr[15:8];
      st   = addr[7:0];
      if (bank == 8'h00) begin
         if (sf && st == 8'd1)  return 32'h0;
         else if (st <= 8'd5)   return 32'hF000_0000 | {24'h0, st + 8'd1};
         else                   return 32'h0;
      end else if (bank == 8'h02) begin
         if (st <= 8'd4)        return 32'hADD0_0000 | {24'h0, st};
         else                   return 32'h0;
      end else if (bank == 8'h0F) begin
         return 32'hFA17_0000 | {24'h0, st};
      end
      return 32'h0;
   endfunction

   always_comb bus.instr_mem_data_in = rom_data(bus.instr_mem_addr_out, short_fetch);

   typedef struct {
      logic        run_en;
      logic        halt_req;
      logic        stall;
      logic [7:0]  ir;
      logic [15:0] addr;
      logic        ctrl_on;
      logic        done;
      logic [15:0] retired;
      logic        halted;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input logic r, input logic h, input logic s, input logic [7:0] ir,
                      input logic [15:0] a, input logic c, input logic d,
                      input logic [15:0] ret, input logic hl);
      vec_t v;
      v.run_en = r; v.halt_req = h; v.stall = s; v.ir = ir; v.addr = a;
      v.ctrl_on = c; v.done = d; v.retired = ret; v.halted = hl;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] a, input logic [31:0] c,
                          input logic d, input logic [15:0] ret, input logic hl, input logic f);
      chk({tag, "_addr"},    {16'h0, bus.instr_mem_addr_out}, {16'h0, a});
      chk({tag, "_step"},    {24'h0, bus.step_out},           {24'h0, a[7:0]});
      chk({tag, "_ctrl"},    bus.ctrl_word_out,               c);
      chk({tag, "_done"},    {31'h0, bus.instr_done},         {31'h0, d});
      chk({tag, "_retired"}, {16'h0, bus.retired_count},      {16'h0, ret});
      chk({tag, "_halted"},  {31'h0, bus.halted},             {31'h0, hl});
      chk({tag, "_fault"},   {31'h0, bus.fault},              {31'h0, f});
   endtask

   task automatic drive(input logic r, input logic h, input logic s, input logic [7:0] ir);
      bus.run_en = r; bus.halt_req = h; bus.stall = s; bus.ir_opcode = ir;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic [15:0] ea;

      // Opcode 00: IDLE cycle, then steps 0..6, end marker at 6.
      add(1, 0, 0, 8'h00, 16'h0000, 0, 0, 16'd0, 0);
      for (int s = 0; s <= 5; s++) add(1, 0, 0, 8'h00, {8'h00, 8'(s)}, 1, 0, 16'd0, 0);
      add(1, 0, 0, 8'h00, 16'h0006, 0, 1, 16'd0, 0);
      // ADD with run_en dropped (ignored while running).
      add(0, 0, 0, 8'h02, 16'h0000, 1, 0, 16'd1, 0);
      add(0, 0, 0, 8'h02, 16'h0001, 1, 0, 16'd1, 0);
      add(0, 0, 0, 8'h02, 16'h0002, 1, 0, 16'd1, 0);
      add(0, 0, 0, 8'h02, 16'h0003, 1, 0, 16'd1, 0);
      add(0, 0, 0, 8'h02, 16'h0204, 1, 0, 16'd1, 0);
      add(0, 0, 0, 8'h02, 16'h0205, 0, 1, 16'd1, 0);
      // ADD with a 3-cycle stall at step 2.
      add(0, 0, 0, 8'h02, 16'h0000, 1, 0, 16'd2, 0);
      add(0, 0, 0, 8'h02, 16'h0001, 1, 0, 16'd2, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 8'h02, 16'h0002, 0, 0, 16'd2, 0);
      add(0, 0, 0, 8'h02, 16'h0002, 1, 0, 16'd2, 0);
      add(0, 0, 0, 8'h02, 16'h0003, 1, 0, 16'd2, 0);
      add(0, 0, 0, 8'h02, 16'h0204, 1, 0, 16'd2, 0);
      add(0, 0, 0, 8'h02, 16'h0205, 0, 1, 16'd2, 0);
      // ADD with halt_req from step 1 and a stall over the end marker.
      add(0, 0, 0, 8'h02, 16'h0000, 1, 0, 16'd3, 0);
      add(0, 1, 0, 8'h02, 16'h0001, 1, 0, 16'd3, 0);
      add(0, 1, 0, 8'h02, 16'h0002, 1, 0, 16'd3, 0);
      add(0, 1, 0, 8'h02, 16'h0003, 1, 0, 16'd3, 0);
      add(0, 1, 0, 8'h02, 16'h0204, 1, 0, 16'd3, 0);
      add(0, 1, 1, 8'h02, 16'h0205, 0, 0, 16'd3, 0);
      add(0, 1, 0, 8'h02, 16'h0205, 0, 1, 16'd3, 0);
      // HALT: held by halt_req, then released.
      add(1, 1, 0, 8'h00, 16'h0000, 0, 0, 16'd4, 1);
      add(1, 0, 0, 8'h00, 16'h0000, 0, 0, 16'd4, 1);
      add(1, 0, 0, 8'h00, 16'h0000, 1, 0, 16'd4, 0);
      add(1, 0, 0, 8'h00, 16'h0001, 1, 0, 16'd4, 0);
      add(1, 0, 0, 8'h00, 16'h0002, 1, 0, 16'd4, 0);
      add(1, 0, 0, 8'h00, 16'h0003, 1, 0, 16'd4, 0);

      short_fetch = 1'b0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      chk_all("reset", 16'h0000, 32'h0, 1'b0, 16'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2;
      chk_all("post_reset", 16'h0000, 32'h0, 1'b0, 16'd0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clk);
         drive(v.run_en, v.halt_req, v.stall, v.ir);
         #2;
         chk_all($sformatf("row%0d", i), v.addr,
                 v.ctrl_on ? rom_data(v.addr, 1'b0) : 32'h0, v.done, v.retired, v.halted, 1'b0);
      end

      // Asynchronous reset at step 4 abandons the instruction.
      @(negedge clk);
      #2;
      chk("rst_mid_pre_addr", {16'h0, bus.instr_mem_addr_out}, 32'h0000_0004);
      rst = 1'b1;
      #1;
      chk_all("rst_mid", 16'h0000, 32'h0, 1'b0, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);

      // Step overflow on opcode 0F: fault and sticky halt.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 8'h0F);
      for (int s = 0; s <= 15; s++) begin
         @(negedge clk);
         #2;
         ea = (s <= 3) ? {8'h00, 8'(s)} : {8'h0F, 8'(s)};
         chk_all($sformatf("ovf_s%0d", s), ea, rom_data(ea, 1'b0), 1'b0, 16'd0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #2;
         chk_all($sformatf("fault_hold%0d", k), 16'h0000, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1);
      end
      do_reset();
      #2;
      chk("fault_cleared", {31'h0, bus.fault}, 32'h0);

      // Fetch-only instruction: end marker at step 1.
      short_fetch = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #2;
      chk_all("short_s0", 16'h0000, rom_data(16'h0000, 1'b1), 1'b0, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      chk_all("short_s1", 16'h0001, 32'h0, 1'b1, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      chk_all("short_next", 16'h0000, rom_data(16'h0000, 1'b1), 1'b0, 16'd1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
